vid_timing_gen: RTL and testbench
=================================

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

Interface
REQ-001 SHALL have parameter DW, default 24, meaning pixel data width.
REQ-002 SHALL have parameter H_ACTIVE, default 1024, meaning active pixels per line.
REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 24/136/160, meaning horizontal front porch/sync/back porch in clocks.
REQ-004 SHALL have parameter V_ACTIVE, default 768, meaning active lines per frame.
REQ-005 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 3/6/29, meaning vertical front porch/sync/back porch in lines.
REQ-006 SHALL have parameters HS_POL/VS_POL, default 0/0, meaning asserted sync level.
REQ-007 SHALL have port pixelclk, input, 1, the single clock; reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port en, input, 1, meaning run timing when high.
REQ-009 SHALL have port o_req, output, 1, meaning upstream must present the next pixel on i_data one cycle later.
REQ-010 SHALL have port i_data, input, DW, meaning the upstream pixel.
REQ-011 SHALL have ports box_en, input, 1; box_l/box_r/box_t/box_b, input, 12 each; box_color, input, DW, meaning the ROI rectangle overlay.
REQ-012 SHALL have ports o_hsync/o_vsync/o_de, output, 1 each; o_data, output, DW; hcount/vcount, output, 12 each; o_sof, output, 1.

Function
REQ-013 Internal h_cnt SHALL run 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344), and wrap to 0; v_cnt SHALL increment on h wrap, run 0..V_TOTAL-1 (806), and wrap to 0.
REQ-014 Region order per axis SHALL be active [0, ACTIVE), front porch, sync, back porch; sync SHALL be asserted for cnt in [ACTIVE+FP, ACTIVE+FP+SYNC).
REQ-015 o_req SHALL be high exactly when en=1 and h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-016 i_data SHALL be sampled one cycle after o_req and registered, giving o_data one cycle later.
REQ-017 o_hsync, o_vsync, o_de, hcount and vcount SHALL be delayed two cycles from the counters, so o_de rises exactly 2 cycles after o_req and is aligned with o_data.
REQ-018 hcount/vcount SHALL equal the pipelined h_cnt/v_cnt during o_de and SHALL be 0 when o_de=0.
REQ-019 o_data SHALL be 0 when o_de=0.
REQ-020 o_sof SHALL be a one-cycle pulse aligned with o_de at hcount=0 and vcount=0.
REQ-021 Box inputs SHALL be latched when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, and on the first enabled cycle after reset or en rising; changes mid-frame SHALL NOT take effect until the next frame.
REQ-022 A pixel SHALL be on-border when latched box_en=1, box_l<=box_r, box_t<=box_b, it lies inside [box_l,box_r]x[box_t,box_b], and hcount<box_l+2 or hcount+2>box_r or vcount<box_t+2 or vcount+2>box_b.
REQ-023 Border comparisons SHALL be done in 13-bit unsigned arithmetic with no wrap-around.
REQ-024 On-border pixels SHALL output box_color on o_data; all other active pixels SHALL output the registered i_data.
REQ-025 Degenerate boxes (box_l>box_r or box_t>box_b) SHALL produce no overlay.
REQ-026 en=0 SHALL clear and hold h_cnt and v_cnt at 0 and force o_req=0; the pipeline SHALL drain within 2 cycles, with syncs going inactive.
REQ-027 On en rising, the frame SHALL start at h_cnt=0, v_cnt=0, with o_req high in that same cycle.

Reset
REQ-028 While reset=1, h_cnt, v_cnt, the pipeline registers, o_req, o_de, o_data, hcount, vcount and o_sof SHALL be 0, and o_hsync=~HS_POL, o_vsync=~VS_POL.
REQ-029 Reset mid-frame SHALL abort the frame; the first cycle after release with en=1 SHALL behave as REQ-027.
REQ-030 reset SHALL take priority over en.

Structure
REQ-031 Package vid_timing_pkg SHALL hold the XGA timing constants, H_TOTAL/V_TOTAL derivations and the border thickness constant (2).
REQ-032 One axis counter-plus-region decoder sub-module, vtg_axis, SHALL be instantiated twice (h and v) with a count-enable input.

Verification
REQ-033 Reset then en=1 for 2 frames -> o_de high 1024 cycles per line; line period 1344; o_hsync low for 136 cycles starting 1048 cycles after o_de rises; 768 active lines; frame period 1083264 cycles.
REQ-034 i_data=h_cnt-indexed ramp driven on the cycle after o_req -> o_data at hcount=N equals ramp value N, with o_de exactly 2 cycles after o_req.
REQ-035 box_en=1, box=(100,200,50,60), box_color=24'hFF0000 -> red at hcount 100,101,199,200 on lines 52-58, full rows on lines 50,51,59,60, ramp elsewhere.
REQ-036 Box changed to (0,0,0,0) at vcount=300 -> current frame unchanged; next frame shows only pixel (0,0) red; box_l=5, box_r=4 -> no overlay.
REQ-037 reset pulsed at vcount=400 -> outputs at reset values during reset; o_sof 2 cycles after release; o_vsync inactive in between.
REQ-038 en dropped at vcount=10 for 100 cycles -> o_de low within 2 cycles; restart gives o_sof 2 cycles after en rises.

Source files
------------

// File: rtl/vid_timing_pkg.sv
// XGA video timing constants and helpers shared by the timing generator
// and its axis counters.
package vid_timing_pkg;

  localparam int CW = 12;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int XGA_H_TOTAL = axis_total(XGA_H_ACTIVE, XGA_H_FP, XGA_H_SYNC, XGA_H_BP);
  localparam int XGA_V_TOTAL = axis_total(XGA_V_ACTIVE, XGA_V_FP, XGA_V_SYNC, XGA_V_BP);

  // ROI overlay line thickness in pixels
  localparam int BORDER = 2;

  typedef enum logic [1:0] {
    RGN_ACTIVE,
    RGN_FP,
    RGN_SYNC,
    RGN_BP
  } region_e;

endpackage

// File: rtl/vtg_axis.sv
// One timing axis: a wrapping position counter plus a decoder that splits
// the line (or frame) into active, front porch, sync and back porch.
module vtg_axis
  import vid_timing_pkg::*;
#(
  parameter int ACTIVE = XGA_H_ACTIVE,
  parameter int FP     = XGA_H_FP,
  parameter int SYNC   = XGA_H_SYNC,
  parameter int BP     = XGA_H_BP
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic          clr,
  input  logic          cnt_en,
  output logic [CW-1:0] cnt,
  output logic          active,
  output logic          sync,
  output logic          last
);

  localparam int            TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] FP_END   = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);

  region_e region;

  always_ff @(posedge pixelclk) begin
    if (reset || clr)
      cnt <= '0;
    else if (cnt_en)
      cnt <= last ? '0 : cnt + 1'b1;
  end

  assign last = (cnt == LAST_CNT);

  always_comb begin
    region = RGN_BP;
    if (cnt < ACT_END)
      region = RGN_ACTIVE;
    else if (cnt < FP_END)
      region = RGN_FP;
    else if (cnt < SYNC_END)
      region = RGN_SYNC;
  end

  assign active = (region == RGN_ACTIVE);
  assign sync   = (region == RGN_SYNC);

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator with pull-style pixel request and a per-frame
// latched ROI rectangle overlay; outputs lag the counters by two cycles.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int   DW       = 24,
  parameter int   H_ACTIVE = XGA_H_ACTIVE,
  parameter int   H_FP     = XGA_H_FP,
  parameter int   H_SYNC   = XGA_H_SYNC,
  parameter int   H_BP     = XGA_H_BP,
  parameter int   V_ACTIVE = XGA_V_ACTIVE,
  parameter int   V_FP     = XGA_V_FP,
  parameter int   V_SYNC   = XGA_V_SYNC,
  parameter int   V_BP     = XGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic          pixelclk,
  input  logic          reset,
  input  logic          en,
  output logic          o_req,
  input  logic [DW-1:0] i_data,
  input  logic          box_en,
  input  logic [11:0]   box_l,
  input  logic [11:0]   box_r,
  input  logic [11:0]   box_t,
  input  logic [11:0]   box_b,
  input  logic [DW-1:0] box_color,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [DW-1:0] o_data,
  output logic [11:0]   hcount,
  output logic [11:0]   vcount,
  output logic          o_sof
);

  logic [11:0] h_cnt, v_cnt;
  logic        h_act, h_sync, h_last;
  logic        v_act, v_sync, v_last;

  vtg_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
    .pixelclk(pixelclk), .reset(reset), .clr(~en), .cnt_en(en),
    .cnt(h_cnt), .active(h_act), .sync(h_sync), .last(h_last)
  );

  vtg_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
    .pixelclk(pixelclk), .reset(reset), .clr(~en), .cnt_en(en & h_last),
    .cnt(v_cnt), .active(v_act), .sync(v_sync), .last(v_last)
  );

  assign o_req = en & ~reset & h_act & v_act;

  logic          de1, hs1, vs1, en_q;
  logic [11:0]   h1, v1;
  logic          bx_en;
  logic [11:0]   bx_l, bx_r, bx_t, bx_b;
  logic [DW-1:0] bx_color;
  logic          box_load;

  // Box is sampled at frame boundaries only so a frame never shows a torn rectangle
  assign box_load = en & (~en_q | (h_last & v_last));

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      de1      <= 1'b0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      h1       <= '0;
      v1       <= '0;
      en_q     <= 1'b0;
      bx_en    <= 1'b0;
      bx_l     <= '0;
      bx_r     <= '0;
      bx_t     <= '0;
      bx_b     <= '0;
      bx_color <= '0;
    end else begin
      de1  <= o_req;
      hs1  <= en & h_sync;
      vs1  <= en & v_sync;
      h1   <= h_cnt;
      v1   <= v_cnt;
      en_q <= en;
      if (box_load) begin
        bx_en    <= box_en;
        bx_l     <= box_l;
        bx_r     <= box_r;
        bx_t     <= box_t;
        bx_b     <= box_b;
        bx_color <= box_color;
      end
    end
  end

  // One extra bit keeps the +BORDER terms from wrapping near 4095
  logic [12:0] hx, vy, l13, r13, t13, b13;
  logic        on_border;

  assign hx  = {1'b0, h1};
  assign vy  = {1'b0, v1};
  assign l13 = {1'b0, bx_l};
  assign r13 = {1'b0, bx_r};
  assign t13 = {1'b0, bx_t};
  assign b13 = {1'b0, bx_b};

  always_comb begin
    on_border = bx_en && (l13 <= r13) && (t13 <= b13)
             && (hx >= l13) && (hx <= r13) && (vy >= t13) && (vy <= b13)
             && ((hx < l13 + 13'(BORDER)) || (hx + 13'(BORDER) > r13)
              || (vy < t13 + 13'(BORDER)) || (vy + 13'(BORDER) > b13));
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      o_de    <= 1'b0;
      o_hsync <= ~HS_POL;
      o_vsync <= ~VS_POL;
      o_data  <= '0;
      hcount  <= '0;
      vcount  <= '0;
      o_sof   <= 1'b0;
    end else begin
      o_de    <= de1;
      o_hsync <= hs1 ? HS_POL : ~HS_POL;
      o_vsync <= vs1 ? VS_POL : ~VS_POL;
      o_data  <= !de1 ? '0 : (on_border ? bx_color : i_data);
      hcount  <= de1 ? h1 : '0;
      vcount  <= de1 ? v1 : '0;
      o_sof   <= de1 && (h1 == '0) && (v1 == '0);
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen on a shrunken raster, compared
// against a frame-position model plus directed multi-cycle sequences.
module tb_vid_timing_gen;

  localparam int   DW    = 24;
  localparam int   HA    = 16, HF = 2, HSY = 3, HB = 4;
  localparam int   VA    = 12, VF = 1, VSY = 2, VB = 2;
  localparam int   HT    = HA + HF + HSY + HB;
  localparam int   VT    = VA + VF + VSY + VB;
  localparam int   FRAME = HT * VT;
  localparam logic HSP   = 1'b0;
  localparam logic VSP   = 1'b1;
  localparam logic [DW-1:0] RED = 24'hFF0000;

  logic          pixelclk = 1'b0;
  logic          reset, en, o_req, box_en;
  logic          o_hsync, o_vsync, o_de, o_sof;
  logic [DW-1:0] i_data, box_color, o_data;
  logic [11:0]   box_l, box_r, box_t, box_b, hcount, vcount;

  vid_timing_gen #(
    .DW(DW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .pixelclk(pixelclk), .reset(reset), .en(en), .o_req(o_req), .i_data(i_data),
    .box_en(box_en), .box_l(box_l), .box_r(box_r), .box_t(box_t), .box_b(box_b),
    .box_color(box_color), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_data(o_data), .hcount(hcount), .vcount(vcount), .o_sof(o_sof)
  );

  initial forever #5 pixelclk = ~pixelclk;

  typedef struct {
    logic          de, hs, vs, border;
    int            h, v;
    logic [DW-1:0] color;
  } pix_t;

  typedef struct {
    logic          de, hs, vs, sof;
    logic [11:0]   hc, vc;
    logic [DW-1:0] data;
  } out_t;

  typedef struct {
    logic        en;
    logic [11:0] l, r, t, b;
    int          exp_red;
  } box_vec_t;

  int            errors = 0, checks = 0;
  int            pos = 0;
  logic          run_prev = 1'b0;
  logic          m_en = 1'b0;
  int            m_l = 0, m_r = 0, m_t = 0, m_b = 0;
  logic [DW-1:0] m_color = '0;
  pix_t          prev_pix, cur_pix;
  out_t          exp_out, s;
  logic          s_req;
  logic          exp_valid = 1'b0;
  logic          ramp_mode = 1'b0;
  logic          counting = 1'b0;
  int            red_count = 0;

  function automatic pix_t idle_pix();
    pix_t p;
    p.de = 1'b0; p.hs = 1'b0; p.vs = 1'b0; p.border = 1'b0;
    p.h = 0; p.v = 0; p.color = '0;
    return p;
  endfunction

  function automatic out_t idle_out();
    out_t o;
    o.de = 1'b0; o.hs = ~HSP; o.vs = ~VSP; o.sof = 1'b0;
    o.hc = '0; o.vc = '0; o.data = '0;
    return o;
  endfunction

  function automatic logic [63:0] pack(input out_t o);
    return {12'b0, o.de, o.hs, o.vs, o.sof, o.hc, o.vc, o.data};
  endfunction

  function automatic logic [DW-1:0] ramp(input int n);
    return DW'(n * 5 + 7);
  endfunction

  // Border = inside the rectangle but not inside the rectangle shrunk by 2
  function automatic logic in_border(input int x, input int y);
    if (!m_en || m_l > m_r || m_t > m_b) return 1'b0;
    if (x < m_l || x > m_r || y < m_t || y > m_b) return 1'b0;
    return !(x >= m_l + 2 && x <= m_r - 2 && y >= m_t + 2 && y <= m_b - 2);
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One pixel clock: drive i_data, check, then advance the model across the edge
  task automatic apply_stimulus();
    int   hx, vy;
    logic running;
    i_data  = ramp_mode ? ramp(prev_pix.h) : {1'b0, 23'($urandom)};
    hx      = pos % HT;
    vy      = pos / HT;
    running = en && !reset;
    if (running && (!run_prev || pos == FRAME - 1)) begin
      m_en = box_en; m_l = box_l; m_r = box_r; m_t = box_t; m_b = box_b; m_color = box_color;
    end
    cur_pix.de     = running && hx < HA && vy < VA;
    cur_pix.hs     = running && hx >= HA + HF && hx < HA + HF + HSY;
    cur_pix.vs     = running && vy >= VA + VF && vy < VA + VF + VSY;
    cur_pix.h      = hx;
    cur_pix.v      = vy;
    cur_pix.border = cur_pix.de && in_border(hx, vy);
    cur_pix.color  = m_color;
    #1;
    s_req = o_req;
    s.de = o_de; s.hs = o_hsync; s.vs = o_vsync; s.sof = o_sof;
    s.hc = hcount; s.vc = vcount; s.data = o_data;
    check_output("o_req", 64'(s_req), 64'(cur_pix.de));
    if (exp_valid) check_output("outputs", pack(s), pack(exp_out));
    if (counting && s.de && s.data == RED) red_count++;
    @(posedge pixelclk);
    if (reset) begin
      exp_out = idle_out();
    end else begin
      exp_out.de   = prev_pix.de;
      exp_out.hs   = prev_pix.hs ? HSP : ~HSP;
      exp_out.vs   = prev_pix.vs ? VSP : ~VSP;
      exp_out.hc   = prev_pix.de ? 12'(prev_pix.h) : 12'd0;
      exp_out.vc   = prev_pix.de ? 12'(prev_pix.v) : 12'd0;
      exp_out.sof  = prev_pix.de && prev_pix.h == 0 && prev_pix.v == 0;
      exp_out.data = !prev_pix.de ? '0 : (prev_pix.border ? prev_pix.color : i_data);
    end
    exp_valid = 1'b1;
    prev_pix  = reset ? idle_pix() : cur_pix;
    run_prev  = running;
    pos       = running ? (pos + 1) % FRAME : 0;
    #1;
  endtask

  task automatic wait_sof(input string name);
    int n = 0;
    do begin
      apply_stimulus();
      n++;
    end while (!s.sof && n < FRAME + 10);
    check_output(name, 64'(s.sof), 64'd1);
  endtask

  task automatic wait_line(input int line, input string name);
    int n = 0;
    do begin
      apply_stimulus();
      n++;
    end while (!(s.de && s.vc == 12'(line)) && n < FRAME + 10);
    check_output(name, 64'(s.de && s.vc == 12'(line)), 64'd1);
  endtask

  initial begin
    box_vec_t vecs[9];
    int de_tot, de_line0, hs_off, hs_len, lines, vs_cnt, ramp_bad, ramp_cnt;
    logic prev_de;

    vecs[0] = '{1'b1, 12'd2,    12'd9,    12'd1,  12'd7,  44};
    vecs[1] = '{1'b1, 12'd0,    12'd0,    12'd0,  12'd0,  1};
    vecs[2] = '{1'b1, 12'd5,    12'd4,    12'd0,  12'd3,  0};
    vecs[3] = '{1'b1, 12'd0,    12'd15,   12'd6,  12'd5,  0};
    vecs[4] = '{1'b0, 12'd2,    12'd9,    12'd1,  12'd7,  0};
    vecs[5] = '{1'b1, 12'd0,    12'd15,   12'd0,  12'd11, 96};
    vecs[6] = '{1'b1, 12'd14,   12'd20,   12'd10, 12'd20, 4};
    vecs[7] = '{1'b1, 12'd3,    12'd4,    12'd3,  12'd4,  4};
    vecs[8] = '{1'b1, 12'd4095, 12'd4095, 12'd0,  12'd0,  0};

    prev_pix = idle_pix();
    cur_pix  = idle_pix();
    exp_out  = idle_out();
    reset = 1'b1; en = 1'b0; box_en = 1'b0; box_color = RED;
    box_l = '0; box_r = '0; box_t = '0; box_b = '0; i_data = '0;
    repeat (3) apply_stimulus();
    check_output("reset_state", pack(s), pack(idle_out()));

    ramp_mode = 1'b1;
    reset = 1'b0; en = 1'b1;
    apply_stimulus();
    check_output("req_on_start", 64'(s_req), 64'd1);
    apply_stimulus();
    apply_stimulus();
    check_output("sof_after_start", 64'(s.sof), 64'd1);

    // Offset 0 is the first active pixel of a frame; scan exactly one frame
    de_tot = 0; de_line0 = 0; hs_off = -1; hs_len = 0; lines = 0; vs_cnt = 0;
    ramp_bad = 0; ramp_cnt = 0; prev_de = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) apply_stimulus();
      if (s.de) de_tot++;
      if (s.de && i < HT) de_line0++;
      if (s.hs == HSP && hs_off < 0) hs_off = i;
      if (s.hs == HSP && i < HT) hs_len++;
      if (s.vs == VSP) vs_cnt++;
      if (s.de && !prev_de) lines++;
      if (s.de) begin
        ramp_cnt++;
        if (s.data !== ramp(int'(s.hc))) ramp_bad++;
      end
      prev_de = s.de;
    end
    check_output("de_per_frame", 64'(de_tot), 64'(HA * VA));
    check_output("de_per_line", 64'(de_line0), 64'(HA));
    check_output("hsync_offset", 64'(hs_off), 64'(HA + HF));
    check_output("hsync_width", 64'(hs_len), 64'(HSY));
    check_output("active_lines", 64'(lines), 64'(VA));
    check_output("vsync_cycles", 64'(vs_cnt), 64'(VSY * HT));
    check_output("ramp_pixels", 64'(ramp_cnt), 64'(HA * VA));
    check_output("ramp_data", 64'(ramp_bad), 64'd0);
    apply_stimulus();
    check_output("frame_period", 64'(s.sof), 64'd1);
    ramp_mode = 1'b0;

    for (int k = 0; k < 9; k++) begin
      wait_line(VA / 2, "box_midframe");
      box_en = vecs[k].en;
      box_l = vecs[k].l; box_r = vecs[k].r; box_t = vecs[k].t; box_b = vecs[k].b;
      wait_sof("box_next_frame");
      red_count = (s.de && s.data == RED) ? 1 : 0;
      counting = 1'b1;
      repeat (FRAME - 1) apply_stimulus();
      counting = 1'b0;
      check_output($sformatf("box_red_count_%0d", k), 64'(red_count), 64'(vecs[k].exp_red));
    end

    for (int k = 0; k < 4; k++) begin
      wait_line(3, "rand_box_line");
      box_en    = ($urandom_range(0, 3) != 0);
      box_l     = 12'($urandom_range(0, HA + 2));
      box_r     = 12'($urandom_range(0, HA + 2));
      box_t     = 12'($urandom_range(0, VA + 2));
      box_b     = 12'($urandom_range(0, VA + 2));
      box_color = {1'b1, 23'($urandom)};
      repeat (2 * FRAME) apply_stimulus();
    end

    wait_line(3, "en_drop_line");
    en = 1'b0;
    repeat (3) apply_stimulus();
    check_output("de_drained", 64'(s.de), 64'd0);
    repeat (97) apply_stimulus();
    en = 1'b1;
    apply_stimulus();
    check_output("req_on_en", 64'(s_req), 64'd1);
    apply_stimulus();
    apply_stimulus();
    check_output("sof_after_en", 64'(s.sof), 64'd1);

    wait_line(6, "reset_line");
    reset = 1'b1;
    apply_stimulus();
    apply_stimulus();
    check_output("in_reset", pack(s), pack(idle_out()));
    apply_stimulus();
    apply_stimulus();
    reset = 1'b0;
    apply_stimulus();
    check_output("req_after_reset", 64'(s_req), 64'd1);
    apply_stimulus();
    apply_stimulus();
    check_output("sof_after_reset", 64'(s.sof), 64'd1);

    repeat (FRAME) apply_stimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
